// File: rtl/sort_serializer.sv
// sort_serializer: captures a 5-word sorted block (rank 1 = largest) and streams
// it out one word per accepted transfer over a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset
//   load       capture request (honoured only while idle)
//   in1..in5   16-bit sorter result words, rank 1 to rank 5
//   busy       a block is held or being streamed
//   out_data   current stream word (0 while idle)
//   out_valid  out_data is valid (same as busy)
//   out_ready  downstream accepts the current word
//   out_last   current word is the final word of the block
//   order_err  last captured block was not in non-increasing order
//
// Build option: define SORT_SERIALIZER_DEDUP_EN to drop words equal to their
// higher-ranked neighbour, so a block streams 1 to 5 distinct words.

module sort_serializer (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] in1,
   input  logic [15:0] in2,
   input  logic [15:0] in3,
   input  logic [15:0] in4,
   input  logic [15:0] in5,
   output logic        busy,
   output logic [15:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        order_err
);

   typedef enum logic {
      StIdle = 1'b0,
      StSend = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [2:0]  next_idx;
   logic        final_word;
   logic [15:0] word_q [1:5];
   logic [15:0] word_d [1:5];
   logic [15:0] in_w   [1:5];
   logic        order_err_q, order_err_d;
   logic        order_bad;

   assign in_w[1] = in1;
   assign in_w[2] = in2;
   assign in_w[3] = in3;
   assign in_w[4] = in4;
   assign in_w[5] = in5;

   // Any rising step between adjacent ranks; equal neighbours are legal.
   assign order_bad = (in1 < in2) | (in2 < in3) | (in3 < in4) | (in4 < in5);

`ifdef SORT_SERIALIZER_DEDUP_EN
   logic [5:1] keep_q, keep_d, keep_in;
   logic [2:0] last_q, last_d, last_in;

   // Keep mask and index of the highest kept word, evaluated on the live inputs.
   always_comb begin
      keep_in = 5'b00001;
      for (int k = 2; k <= 5; k++) begin
         keep_in[k] = (in_w[k] != in_w[k-1]);
      end
      last_in = 3'd1;
      for (int k = 2; k <= 5; k++) begin
         if (keep_in[k]) last_in = 3'(k);
      end
   end

   // Smallest kept index above the current one; scanning downwards lets it win.
   always_comb begin
      next_idx = idx_q;
      for (int k = 5; k >= 2; k--) begin
         if (k > int'(idx_q) && keep_q[k]) next_idx = 3'(k);
      end
   end

   assign final_word = (idx_q == last_q);
`else
   assign next_idx   = idx_q + 3'd1;
   assign final_word = (idx_q == 3'd5);
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      word_d      = word_q;
      order_err_d = order_err_q;
`ifdef SORT_SERIALIZER_DEDUP_EN
      keep_d      = keep_q;
      last_d      = last_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (load) begin
               word_d      = in_w;
               idx_d       = 3'd1;
               order_err_d = order_bad;
               state_d     = StSend;
`ifdef SORT_SERIALIZER_DEDUP_EN
               keep_d      = keep_in;
               last_d      = last_in;
`endif
            end
         end
         StSend: begin
            // load is deliberately not looked at here, even on the final transfer.
            if (out_ready) begin
               if (final_word) begin
                  state_d = StIdle;
                  idx_d   = 3'd1;
               end else begin
                  idx_d = next_idx;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         idx_q       <= 3'd1;
         order_err_q <= 1'b0;
         for (int k = 1; k <= 5; k++) begin
            word_q[k] <= '0;
         end
`ifdef SORT_SERIALIZER_DEDUP_EN
         keep_q      <= 5'b00001;
         last_q      <= 3'd1;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         order_err_q <= order_err_d;
         word_q      <= word_d;
`ifdef SORT_SERIALIZER_DEDUP_EN
         keep_q      <= keep_d;
         last_q      <= last_d;
`endif
      end
   end

   assign busy      = (state_q == StSend);
   assign out_valid = busy;
   assign out_last  = busy && final_word;
   assign order_err = order_err_q;

   always_comb begin
      out_data = '0;
      if (busy) out_data = word_q[idx_q];
   end

endmodule
